key_nibble_serial_tx: RTL

//  Serial transmitter upstream of the 4-bit key-code receiver. Buffers key-code

---
 rtl/key_nibble_serial_tx.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_nibble_serial_tx.sv
// key_nibble_serial_tx
// Serial transmitter feeding the 4-bit key-code receiver. Nibbles are buffered
// in a small FIFO and sent one per frame on a line that idles high:
//   start(0), D0..D3 (LSB first), STOP_CYCLES stop bits(1).
// Frames run back-to-back whenever another nibble is waiting at the last stop bit.
//
// Optional feature (macro KEY_TX_WORD_EN): a 24-bit word port. An accepted word
// is sent as six nibbles, most significant first, ahead of anything in the FIFO.
// Without the macro the FIFO is the only source and the word ports do not exist.

module key_nibble_serial_tx #(
    parameter int DEPTH       = 4,  // FIFO entries, power of 2, >= 2
    parameter int AW          = 2,  // log2(DEPTH)
    parameter int STOP_CYCLES = 1   // stop-bit cycles per frame, 1..7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [3:0]    i_nibble,
`ifdef KEY_TX_WORD_EN
    input  logic          i_word_valid,
    input  logic [23:0]   i_word,
    output logic          o_word_ready,
`endif
    output logic          o_ready,
    output logic          o_tx_bit,
    output logic          o_busy,
    output logic [AW:0]   o_fifo_count,
    output logic [7:0]    o_frames
);

    // Line state: each value names what is on the line during the current cycle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_CYCLES - 1);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          fifo_pop;
    logic          fifo_avail;

    assign o_ready      = (count < FULL_COUNT);
    assign push         = i_valid && o_ready;
    assign fifo_avail   = (count != '0);
    assign o_fifo_count = count;

    // FIFO storage write.
    // NOTE: the storage array is deliberately not reset; count and the pointers
    // alone decide which entries are valid, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= i_nibble;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (fifo_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer source selection
    // ------------------------------------------------------------------
    logic       pop_req;     // FSM loads the shift register this edge
    logic       src_avail;   // some source has a nibble ready
    logic [3:0] src_nibble;  // nibble the FSM would load

`ifdef KEY_TX_WORD_EN
    logic [23:0] word_q;
    logic [2:0]  word_cnt;   // nibbles of word_q still to send, 6..0
    logic        word_avail;
    logic        word_accept;
    logic        word_pop;
    logic [3:0]  word_nibble;

    assign o_word_ready = (word_cnt == 3'd0);
    assign word_accept  = i_word_valid && o_word_ready;
    assign word_avail   = (word_cnt != 3'd0);
    assign word_pop     = pop_req && word_avail;
    // A word in progress holds off the FIFO; pushes into the FIFO still land.
    assign fifo_pop     = pop_req && !word_avail;
    assign src_avail    = word_avail || fifo_avail;
    assign src_nibble   = word_avail ? word_nibble : mem[rptr];

    // Pick the next word nibble, most significant first.
    always_comb begin
        word_nibble = 4'h0;
        case (word_cnt)
            3'd6:    word_nibble = word_q[23:20];
            3'd5:    word_nibble = word_q[19:16];
            3'd4:    word_nibble = word_q[15:12];
            3'd3:    word_nibble = word_q[11:8];
            3'd2:    word_nibble = word_q[7:4];
            3'd1:    word_nibble = word_q[3:0];
            default: word_nibble = 4'h0;
        endcase
    end

    // Word holding register and remaining-nibble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            word_cnt <= 3'd0;
        end else if (word_accept) begin
            word_q   <= i_word;
            word_cnt <= 3'd6;
        end else if (word_pop) begin
            word_cnt <= word_cnt - 3'd1;
        end
    end
`else
    assign fifo_pop   = pop_req;
    assign src_avail  = fifo_avail;
    assign src_nibble = mem[rptr];
`endif

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic       tx_q, tx_d;
    logic [3:0] sh_q, sh_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] stop_q, stop_d;
    logic       busy_q;
    logic [7:0] frames_q;
    logic       frame_done;

    // State, line and frame-counter registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            sh_q     <= 4'h0;
            idx_q    <= 2'd0;
            stop_q   <= 3'd0;
            busy_q   <= 1'b0;
            frames_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            busy_q  <= (state_d != S_IDLE);
            if (frame_done) begin
                frames_q <= frames_q + 8'd1;
            end
        end
    end

    // Next state, next line value and pop request for the coming edge.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        pop_req    = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (src_avail) begin
                    pop_req = 1'b1;
                    sh_d    = src_nibble;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                tx_d    = sh_q[0];
                idx_d   = 2'd0;
                state_d = S_DATA;
            end

            S_DATA: begin
                if (idx_q == 2'd3) begin
                    tx_d    = 1'b1;
                    stop_d  = 3'd0;
                    state_d = S_STOP;
                end else begin
                    idx_d = idx_q + 2'd1;
                    tx_d  = sh_q[idx_q + 2'd1];
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (stop_q == STOP_LAST) begin
                    frame_done = 1'b1;
                    // Back-to-back: start the next frame with no idle cycle.
                    if (src_avail) begin
                        pop_req = 1'b1;
                        sh_d    = src_nibble;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stop_d = stop_q + 3'd1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_tx_bit = tx_q;
    assign o_busy   = busy_q;
    assign o_frames = frames_q;

endmodule
